// File: rtl/westminster_chime.sv
// Westminster quarter chime sequencer: plays the change-ringing quarters on
// ena ticks and, at the top of the hour, strikes the hour bell.
module westminster_chime #(
  parameter int NOTE_TICKS   = 1,
  parameter int STRIKE_TICKS = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ena,
  input  logic [7:0] i_hh,
  input  logic [7:0] i_mm,
  input  logic [7:0] i_ss,
  output logic       o_note_valid,
  output logic [1:0] o_note,
  output logic       o_strike,
  output logic       o_busy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_NOTE      = 2'd1;
  localparam logic [1:0] S_STRIKE    = 2'd2;
  localparam logic [3:0] NOTE_LAST   = 4'(NOTE_TICKS - 1);
  localparam logic [3:0] STRIKE_LAST = 4'(STRIKE_TICKS - 1);

  logic [1:0] r_state;
  logic [2:0] r_chg;
  logic [1:0] r_pos;
  logic [1:0] r_chg_left;
  logic       r_hour;
  logic [3:0] r_strikes;
  logic [3:0] r_cnt;
  logic       r_note_valid;
  logic [1:0] r_note;
  logic       r_strike;
  logic       r_busy;

  logic       w_quarter;
  logic [2:0] w_start_chg;
  logic [1:0] w_start_left;
  logic       w_trigger;
  logic [2:0] w_next_chg;
  logic [1:0] w_next_pos;
  logic [1:0] w_next_left;
  logic       w_next_is_last;

  // Bell for position pos of change chg (C1..C5 encoded 0..4).
  function automatic logic [1:0] change_note(input logic [2:0] chg, input logic [1:0] pos);
    logic [1:0] n;
    case ({chg, pos})
      5'b000_00: n = 2'd3;
      5'b000_01: n = 2'd2;
      5'b000_10: n = 2'd1;
      5'b001_00: n = 2'd1;
      5'b001_01: n = 2'd3;
      5'b001_10: n = 2'd2;
      5'b010_00: n = 2'd1;
      5'b010_01: n = 2'd2;
      5'b010_10: n = 2'd3;
      5'b010_11: n = 2'd1;
      5'b011_00: n = 2'd3;
      5'b011_01: n = 2'd1;
      5'b011_10: n = 2'd2;
      5'b100_01: n = 2'd2;
      5'b100_10: n = 2'd3;
      5'b100_11: n = 2'd1;
      default:   n = 2'd0;
    endcase
    return n;
  endfunction

  // Packed-BCD hour to strike count; anything outside 01..12 strikes twelve.
  function automatic logic [3:0] bcd_hours(input logic [7:0] h);
    logic [3:0] r;
    if (h[7:4] == 4'd0 && h[3:0] >= 4'd1 && h[3:0] <= 4'd9) begin
      r = h[3:0];
    end else if (h[7:4] == 4'd1 && h[3:0] <= 4'd2) begin
      r = 4'd10 + h[3:0];
    end else begin
      r = 4'd12;
    end
    return r;
  endfunction

  // Every quarter sequence is a run of consecutive changes, C5 wrapping to C1.
  always_comb begin
    w_quarter    = 1'b1;
    w_start_chg  = 3'd0;
    w_start_left = 2'd0;
    case (i_mm)
      8'h15: begin w_start_chg = 3'd0; w_start_left = 2'd0; end
      8'h30: begin w_start_chg = 3'd1; w_start_left = 2'd1; end
      8'h45: begin w_start_chg = 3'd3; w_start_left = 2'd2; end
      8'h00: begin w_start_chg = 3'd1; w_start_left = 2'd3; end
      default: w_quarter = 1'b0;
    endcase
  end

  assign w_trigger = i_ena && (i_ss == 8'h00) && w_quarter && !r_busy;

  always_comb begin
    if (r_pos == 2'd3) begin
      w_next_pos  = 2'd0;
      w_next_chg  = (r_chg == 3'd4) ? 3'd0 : r_chg + 3'd1;
      w_next_left = r_chg_left - 2'd1;
    end else begin
      w_next_pos  = r_pos + 2'd1;
      w_next_chg  = r_chg;
      w_next_left = r_chg_left;
    end
    w_next_is_last = (w_next_left == 2'd0) && (w_next_pos == 2'd3);
  end

  // busy stays high one cycle past the final event, which also blocks retriggers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_chg        <= 3'd0;
      r_pos        <= 2'd0;
      r_chg_left   <= 2'd0;
      r_hour       <= 1'b0;
      r_strikes    <= 4'd0;
      r_cnt        <= 4'd0;
      r_note_valid <= 1'b0;
      r_note       <= 2'd0;
      r_strike     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_note_valid <= 1'b0;
      r_strike     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= 4'd0;
          r_busy <= w_trigger;
          if (w_trigger) begin
            r_state      <= S_NOTE;
            r_chg        <= w_start_chg;
            r_pos        <= 2'd0;
            r_chg_left   <= w_start_left;
            r_hour       <= (i_mm == 8'h00);
            r_strikes    <= bcd_hours(i_hh);
            r_note_valid <= 1'b1;
            r_note       <= change_note(w_start_chg, 2'd0);
          end
        end
        S_NOTE: begin
          if (i_ena) begin
            if (r_cnt == NOTE_LAST) begin
              r_cnt        <= 4'd0;
              r_chg        <= w_next_chg;
              r_pos        <= w_next_pos;
              r_chg_left   <= w_next_left;
              r_note_valid <= 1'b1;
              r_note       <= change_note(w_next_chg, w_next_pos);
              if (w_next_is_last) begin
                r_state <= r_hour ? S_STRIKE : S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_STRIKE: begin
          if (i_ena) begin
            if (r_cnt == STRIKE_LAST) begin
              r_cnt     <= 4'd0;
              r_strike  <= 1'b1;
              r_strikes <= r_strikes - 4'd1;
              if (r_strikes == 4'd1) begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_note_valid = r_note_valid;
  assign o_note       = r_note;
  assign o_strike     = r_strike;
  assign o_busy       = r_busy;

endmodule

// File: doc/westminster_chime.md
WESTMINSTER_CHIME -- requirements
Module: westminster_chime

Interface
REQ-001 Parameter NOTE_TICKS, default 1: ena ticks between consecutive note events, legal range 1..15.
REQ-002 Parameter STRIKE_TICKS, default 2: ena ticks from the final note to the first strike, and between strikes, legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ena  input  1  one-second tick qualifier, same strobe that advances the timekeeper.
REQ-006 hh  input  8  hour, packed BCD, 01..12.
REQ-007 mm  input  8  minute, packed BCD, 00..59.
REQ-008 ss  input  8  second, packed BCD, 00..59.
REQ-009 note_valid  output  1  one-cycle pulse marking a note event.
REQ-010 note  output  2  bell index while note_valid is high: 0=B, 1=E, 2=F#, 3=G#; holds its last value otherwise.
REQ-011 strike  output  1  one-cycle pulse marking an hour-bell strike.
REQ-012 busy  output  1  high from the first event through the final event of a sequence.

Function
REQ-013 Trigger: a cycle with ena=1, ss=8'h00 and mm in {8'h00, 8'h15, 8'h30, 8'h45}, while busy=0.
REQ-014 A trigger that arrives while busy=1 is dropped with no effect; no queuing.
REQ-015 Change table, in note order: C1 = 3,2,1,0; C2 = 1,3,2,0; C3 = 1,2,3,1; C4 = 3,1,2,0; C5 = 0,2,3,1.
REQ-016 Sequence per minute value:
- :15 = C1
- :30 = C2,C3
- :45 = C4,C5,C1
- :00 = C2,C3,C4,C5, followed by hour strikes.
REQ-017 The number of hour strikes is hh, converted from BCD and latched in the trigger cycle; hh=8'h00 and any value above 8'h12 or with an invalid digit SHALL strike 12 times.
REQ-018 FSM states:
- IDLE -> NOTE on trigger.
- NOTE -> NOTE while notes remain.
- NOTE -> STRIKE after the last note when mm was 00.
- NOTE -> IDLE after the last note otherwise.
- STRIKE -> IDLE after the last strike.
REQ-019 The first note_valid SHALL occur in the cycle after the trigger cycle, independent of ena.
REQ-020 Each subsequent note SHALL fire on the NOTE_TICKS-th ena=1 cycle after the previous note.
REQ-021 The first strike SHALL fire on the STRIKE_TICKS-th ena=1 cycle after the last note; subsequent strikes SHALL be spaced STRIKE_TICKS ena ticks apart.
REQ-022 Only cycles with ena=1 advance the tick counter; ena=0 freezes the sequence in place with no events.
REQ-023 busy SHALL rise with the first note_valid and fall in the cycle after the final note_valid or strike.
REQ-024 The next trigger is accepted once busy=0, including in the same cycle busy falls.
REQ-025 note_valid and strike SHALL never be high in the same cycle.
REQ-026 hh, mm and ss are sampled only in the trigger cycle; changes during a sequence have no effect.
REQ-027 All outputs SHALL be registered; the maximum sequence length is 16 notes plus 12 strikes.

Reset
REQ-028 In a cycle with reset=1 the FSM SHALL enter IDLE and note_valid, note, strike and busy SHALL be 0 in the following cycle, including mid-sequence.
REQ-029 reset takes priority over a trigger in the same cycle; all counters and latched values clear.

Verification
REQ-030 A bench SHALL cover the following directed scenarios, with ena=1 every cycle unless stated and default parameters:
- Reset: reset=1 for 2 cycles, then release -> note_valid, strike, busy and note all 0; no events while ss is nonzero.
- Quarter hour: mm=15, ss=00 at cycle T -> note 3,2,1,0 at T+1..T+4; busy high T+1..T+4; no strike.
- Full hour: mm=00, hh=03 at T -> 16 notes 1,3,2,0,1,2,3,1,3,1,2,0,0,2,3,1 at T+1..T+16; strikes at T+18, T+20, T+22; busy low at T+23.
- ena gating: mm=30 with ena high every other cycle -> 8 notes (C2 then C3) at twice the spacing; no events in ena=0 cycles.
- Reset mid-sequence: reset asserted during the 5th note of :45 -> all outputs 0 next cycle; a later :15 trigger plays C1 normally.
- Boundary: hh=8'h00 at :00 -> 12 strikes; a second trigger while busy is dropped, with the event count unchanged.
